// File: rtl/instr_mem_sync.sv
// Byte-organised instruction memory: self-clearing after reset, byte-wide loader
// port, one-cycle word fetch. `define INSTR_MEM_MISALIGN_TRAP_EN to trap unaligned fetches.
//
// state    | meaning
// ST_CLEAR | zeroing one entry per cycle; fetch and loader ports not ready
// ST_IDLE  | memory usable; fetches and loader writes accepted every cycle

module instr_mem_sync #(
  parameter int InstrWidth = 32,
  parameter int EntryWidth = 8,
  parameter int AddrWidth  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [AddrWidth-1:0]  fetch_addr,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [InstrWidth-1:0] instr,
  output logic                  instr_fault,
  input  logic                  ld_we,
  input  logic [AddrWidth-1:0]  ld_addr,
  input  logic [EntryWidth-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  init_done
);

  localparam int NB    = InstrWidth / EntryWidth;
  localparam int Depth = 2 ** AddrWidth;

  generate
    if ((InstrWidth % EntryWidth) != 0 || NB < 1) begin : g_bad_width
      $error("instr_mem_sync: InstrWidth must be a non-zero multiple of EntryWidth");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [AddrWidth-1:0]    clr_cnt_q, clr_cnt_d;
  logic                    instr_valid_q, instr_valid_d;
  logic [InstrWidth-1:0]   instr_q, instr_d;
  logic [EntryWidth-1:0]   mem_q [Depth];

  logic                    ready;
  logic                    fetch_acc;
  logic                    mem_we;
  logic [AddrWidth-1:0]    mem_waddr;
  logic [EntryWidth-1:0]   mem_wdata;

  // Readiness is dropped combinationally while rst is high, even before the reset edge.
  assign ready       = (state_q == ST_IDLE) && !rst;
  assign fetch_ready = ready;
  assign ld_ready    = ready;
  assign init_done   = ready;
  assign fetch_acc   = fetch_req && ready;
  assign instr_valid = instr_valid_q && !rst;
  assign instr       = instr_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = !rst;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      clr_cnt_d = clr_cnt_q + AddrWidth'(1);
      if (clr_cnt_q == {AddrWidth{1'b1}}) begin
        state_d = ST_IDLE;
      end
    end else begin
      mem_we = ld_we && ready;
    end
  end

  // Reads sample mem_q before this edge's write lands, giving read-before-write.
  always_comb begin
    instr_valid_d = fetch_acc;
    instr_d       = instr_q;
    if (fetch_acc) begin
      for (int k = 0; k < NB; k++) begin
        instr_d[k*EntryWidth +: EntryWidth] = mem_q[fetch_addr + AddrWidth'(k)];
      end
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
      if ((int'(fetch_addr) % NB) != 0) begin
        instr_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clr_cnt_q     <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef INSTR_MEM_MISALIGN_TRAP_EN
  logic instr_fault_q, instr_fault_d;

  always_comb begin
    instr_fault_d = instr_fault_q;
    if (fetch_acc) begin
      instr_fault_d = (int'(fetch_addr) % NB) != 0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_fault_q <= 1'b0;
    end else begin
      instr_fault_q <= instr_fault_d;
    end
  end

  assign instr_fault = instr_fault_q;
`else
  assign instr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync (AddrWidth=6): directed scenarios plus
// randomized traffic compared against a cycle-level array model every cycle.

module tb_instr_mem_sync;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [5:0]  fetch_addr = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_fault;
  logic        ld_we = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0]  m_mem [DEPTH];
  bit          m_ready = 0;
  int          m_cnt = 0;
  bit          m_valid = 0;
  logic [31:0] m_instr = '0;
  bit          m_fault = 0;

  instr_mem_sync #(.InstrWidth(32), .EntryWidth(8), .AddrWidth(AW)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_fault(instr_fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model update at the edge, full output comparison at the falling edge.
  task automatic cycle();
    int a;
    @(posedge clk);
    if (rst) begin
      m_ready = 0; m_cnt = 0; m_valid = 0; m_instr = '0; m_fault = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1;
      m_valid = 0;
    end else begin
      m_valid = fetch_req;
      if (fetch_req) begin
        a = int'(fetch_addr);
        m_instr = '0;
        for (int k = 0; k < 4; k++) m_instr = m_instr | (32'(m_mem[(a + k) % DEPTH]) << (8 * k));
        m_fault = 0;
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
        if (a % 4 != 0) begin m_instr = '0; m_fault = 1; end
`endif
      end
      if (ld_we) m_mem[ld_addr] = ld_data;
    end
    @(negedge clk);
    chk("init_done",   init_done,   m_ready && !rst);
    chk("fetch_ready", fetch_ready, m_ready && !rst);
    chk("ld_ready",    ld_ready,    m_ready && !rst);
    chk("instr_valid", instr_valid, m_valid && !rst);
    chk("instr",       instr,       m_instr);
    chk("instr_fault", instr_fault, m_fault);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 200) begin cycle(); n++; end
    chk(tag, n, 64);
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    cycle();
    ld_we = 1'b0;
  endtask

  task automatic fetch(input logic [5:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    cycle();
    fetch_req = 1'b0;
  endtask

  initial begin
    logic [7:0] b [4];

    // reset and clear length
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    wait_init("clear_len");
    fetch(6'h00);
    chk("clr_fetch0", instr, 32'h0000_0000);
    cycle();

    // load and fetch
    b[0] = 8'h13; b[1] = 8'h05; b[2] = 8'h10; b[3] = 8'h00;
    for (int i = 0; i < 4; i++) load(6'(8 + i), b[i]);
    fetch(6'h08);
    chk("ld_instr", instr, 32'h0010_0513);
    chk("ld_valid", instr_valid, 1'b1);
    cycle();
    chk("ld_valid_drop", instr_valid, 1'b0);
    chk("ld_instr_hold", instr, 32'h0010_0513);

    // wrap-around
    load(6'h3C, 8'hAA); load(6'h3D, 8'hBB); load(6'h3E, 8'hCC); load(6'h3F, 8'hDD);
    load(6'h00, 8'h11); load(6'h01, 8'h22);
    fetch(6'h3E);
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
    chk("wrap_instr", instr, 32'h0000_0000);
    chk("wrap_fault", instr_fault, 1'b1);
`else
    chk("wrap_instr", instr, 32'h2211_DDCC);
`endif

    // back-to-back fetches
    fetch_req = 1'b1; fetch_addr = 6'h08;
    cycle();
    fetch_addr = 6'h3C;
    cycle();
    chk("b2b_valid", instr_valid, 1'b1);
    chk("b2b_instr", instr, 32'hDDCC_BBAA);
    fetch_req = 1'b0;

    // same-cycle load/fetch collision
    fetch_req = 1'b1; fetch_addr = 6'h10;
    ld_we = 1'b1; ld_addr = 6'h11; ld_data = 8'hFF;
    cycle();
    chk("coll_old", instr, 32'h0000_0000);
    ld_we = 1'b0;
    cycle();
    chk("coll_new", instr, 32'h0000_FF00);
    fetch_req = 1'b0;
    cycle();

`ifdef INSTR_MEM_MISALIGN_TRAP_EN
    fetch(6'h05);
    chk("mis_instr", instr, 32'h0000_0000);
    chk("mis_fault", instr_fault, 1'b1);
    fetch(6'h04);
    chk("al_fault", instr_fault, 1'b0);
`endif

    // fetch accepted right before reset must not show valid
    fetch_req = 1'b1; fetch_addr = 6'h08;
    cycle();
    fetch_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_kill_valid", instr_valid, 1'b0);
    cycle();
    chk("rst_instr", instr, 32'h0000_0000);
    rst = 1'b0;

    // mid-clear reset; loads during clear are dropped
    for (int i = 0; i < 20; i++) begin
      ld_we = 1'b1; ld_addr = 6'($urandom_range(0, 63)); ld_data = 8'($urandom);
      cycle();
    end
    ld_addr = 6'h08; ld_data = 8'h5A;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ld_we = 1'b0;
    wait_init("midclr_len");
    fetch(6'h08);
    chk("midclr_zero", instr, 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      fetch_req  = $urandom_range(0, 1);
      fetch_addr = 6'($urandom_range(0, 63));
      ld_we      = ($urandom_range(0, 2) != 0);
      ld_addr    = 6'($urandom_range(0, 63));
      ld_data    = 8'($urandom);
      cycle();
    end
    rst = 1'b0; fetch_req = 1'b0; ld_we = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
